// File: rtl/i2c_reg_target.sv
// I2C target with an NREG x 8 register file, pointer-based auto-increment writes/reads.
// Define I2C_TGT_GCALL_EN to also accept general-call (address 7'h00, write) transactions.
`timescale 1ns/1ps
module i2c_reg_target #(
  parameter logic [6:0] DEV_ADDR = 7'h50,
  parameter int         NREG     = 16,
  localparam int        AW       = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          scl_i,
  input  logic          sda_i,
  output logic          sda_oe,
  output logic          wr_stb,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  input  logic [AW-1:0] host_raddr,
  output logic [7:0]    host_rdata,
  output logic          busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE
  } state_t;

  state_t          state, state_nxt;
  logic [3:0]      bit_cnt, bit_cnt_nxt;
  logic [7:0]      shift, shift_nxt;
  logic [AW-1:0]   ptr, ptr_nxt, ptr_inc;
  logic            sda_oe_q, sda_oe_nxt;
  logic            busy_q, busy_nxt;
  logic            wr_stb_q, wr_stb_nxt;
  logic [AW-1:0]   wr_addr_q, wr_addr_nxt;
  logic [7:0]      wr_data_q, wr_data_nxt;
  logic            reg_we;
  logic [7:0]      regs [NREG];

  logic scl_p0, scl_p1, scl_p2;
  logic sda_p0, sda_p1, sda_p2;
  logic scl_rise, scl_fall, start_det, stop_det;

  function automatic logic addr_match(input logic [7:0] b);
`ifdef I2C_TGT_GCALL_EN
    return (b[7:1] == DEV_ADDR) || (b == 8'h00);
`else
    return (b[7:1] == DEV_ADDR);
`endif
  endfunction

  // Stage p0/p1: synchronizer; stage p2: history for edge detection (idle bus is high)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_p0 <= 1'b1;
      scl_p1 <= 1'b1;
      scl_p2 <= 1'b1;
      sda_p0 <= 1'b1;
      sda_p1 <= 1'b1;
      sda_p2 <= 1'b1;
    end else begin
      scl_p0 <= scl_i;
      scl_p1 <= scl_p0;
      scl_p2 <= scl_p1;
      sda_p0 <= sda_i;
      sda_p1 <= sda_p0;
      sda_p2 <= sda_p1;
    end
  end

  assign scl_rise  =  scl_p1 & ~scl_p2;
  assign scl_fall  = ~scl_p1 &  scl_p2;
  assign start_det =  scl_p1 &  scl_p2 & ~sda_p1 &  sda_p2;
  assign stop_det  =  scl_p1 &  scl_p2 &  sda_p1 & ~sda_p2;

  assign ptr_inc = ptr + AW'(1);

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift;
    ptr_nxt     = ptr;
    sda_oe_nxt  = sda_oe_q;
    busy_nxt    = busy_q;
    wr_stb_nxt  = 1'b0;
    wr_addr_nxt = wr_addr_q;
    wr_data_nxt = wr_data_q;
    reg_we      = 1'b0;
    if (start_det) begin
      state_nxt   = ADDR;
      bit_cnt_nxt = 4'd0;
      sda_oe_nxt  = 1'b0;
      busy_nxt    = 1'b0;
    end else if (stop_det) begin
      state_nxt  = IDLE;
      sda_oe_nxt = 1'b0;
      busy_nxt   = 1'b0;
    end else begin
      case (state)
        ADDR, PTR, WR_BYTE: begin
          if (scl_rise && bit_cnt < 4'd8) begin
            shift_nxt   = {shift[6:0], sda_p1};
            bit_cnt_nxt = bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            bit_cnt_nxt = 4'd0;
            if (state == ADDR) begin
              if (addr_match(shift)) begin
                state_nxt  = ADDR_ACK;
                sda_oe_nxt = 1'b1;
                busy_nxt   = 1'b1;
              end else begin
                state_nxt = IGNORE;
              end
            end else if (state == PTR) begin
              ptr_nxt    = shift[AW-1:0];
              sda_oe_nxt = 1'b1;
              state_nxt  = PTR_ACK;
            end else begin
              sda_oe_nxt = 1'b1;
              state_nxt  = WR_ACK;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            if (shift[0]) begin
              // First read byte's MSB goes out on the same fall that ends the ACK
              shift_nxt   = regs[ptr];
              sda_oe_nxt  = ~regs[ptr][7];
              bit_cnt_nxt = 4'd1;
              state_nxt   = RD_BYTE;
            end else begin
              sda_oe_nxt  = 1'b0;
              bit_cnt_nxt = 4'd0;
              state_nxt   = PTR;
            end
          end
        end
        PTR_ACK: begin
          if (scl_fall) begin
            sda_oe_nxt  = 1'b0;
            bit_cnt_nxt = 4'd0;
            state_nxt   = WR_BYTE;
          end
        end
        WR_ACK: begin
          if (scl_fall) begin
            reg_we      = 1'b1;
            wr_stb_nxt  = 1'b1;
            wr_addr_nxt = ptr;
            wr_data_nxt = shift;
            ptr_nxt     = ptr_inc;
            sda_oe_nxt  = 1'b0;
            bit_cnt_nxt = 4'd0;
            state_nxt   = WR_BYTE;
          end
        end
        RD_BYTE: begin
          if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sda_oe_nxt  = 1'b0;
              bit_cnt_nxt = 4'd0;
              state_nxt   = RD_ACK;
            end else begin
              shift_nxt   = {shift[6:0], 1'b0};
              sda_oe_nxt  = ~shift[6];
              bit_cnt_nxt = bit_cnt + 4'd1;
            end
          end
        end
        RD_ACK: begin
          // bit_cnt 9 marks a controller ACK seen on the rise; continue on the fall
          if (scl_rise) begin
            if (sda_p1) state_nxt = IGNORE;
            else        bit_cnt_nxt = 4'd9;
          end else if (scl_fall && bit_cnt == 4'd9) begin
            ptr_nxt     = ptr_inc;
            shift_nxt   = regs[ptr_inc];
            sda_oe_nxt  = ~regs[ptr_inc][7];
            bit_cnt_nxt = 4'd1;
            state_nxt   = RD_BYTE;
          end
        end
        IDLE, IGNORE: begin
          state_nxt = state;
        end
        default: begin
          state_nxt  = IDLE;
          sda_oe_nxt = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      bit_cnt   <= 4'd0;
      shift     <= 8'h00;
      ptr       <= '0;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 8'h00;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      shift     <= shift_nxt;
      ptr       <= ptr_nxt;
      sda_oe_q  <= sda_oe_nxt;
      busy_q    <= busy_nxt;
      wr_stb_q  <= wr_stb_nxt;
      wr_addr_q <= wr_addr_nxt;
      wr_data_q <= wr_data_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= 8'h00;
    end else if (reg_we) begin
      regs[ptr] <= shift;
    end
  end

  assign sda_oe     = sda_oe_q;
  assign busy       = busy_q;
  assign wr_stb     = wr_stb_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign host_rdata = regs[host_raddr];

endmodule

// File: tb/tb_i2c_reg_target.sv
// Scoreboard bench for i2c_reg_target: bit-banged I2C controller, queued expected writes/reads.
`timescale 1ns/1ps
module tb_i2c_reg_target;
  localparam time Q = 100ns;

  typedef struct {
    logic [3:0] a;
    logic [7:0] d;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       sda_oe, wr_stb, busy;
  logic [3:0] wr_addr, host_raddr = 4'd0;
  logic [7:0] wr_data, host_rdata;

  int nchecks = 0;
  int nerrors = 0;
  wr_t        exp_wr[$];
  logic [7:0] exp_rd[$];
  logic       watch_quiet = 1'b0;
  logic       oe_seen = 1'b0;
  logic       busy_seen = 1'b0;

  assign sda_line = sda_m & ~sda_oe;

  i2c_reg_target #(.DEV_ADDR(7'h50), .NREG(16)) dut (
    .clk(clk), .rst(rst), .scl_i(scl), .sda_i(sda_line), .sda_oe(sda_oe),
    .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data),
    .host_raddr(host_raddr), .host_rdata(host_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && wr_stb) begin
      if (exp_wr.size() == 0) check("wr_unexpected", 1, 0);
      else begin
        wr_t e;
        e = exp_wr.pop_front();
        check("wr_addr", wr_addr, e.a);
        check("wr_data", wr_data, e.d);
      end
    end
  end

  always @(negedge clk) begin
    if (watch_quiet) begin
      if (sda_oe) oe_seen <= 1'b1;
      if (busy) busy_seen <= 1'b1;
    end
  end

  task automatic bus_start();
    sda_m = 1'b1; #Q;
    scl = 1'b1;   #Q;
    sda_m = 1'b0; #Q;
    scl = 1'b0;   #Q;
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; #Q;
    scl = 1'b1;   #Q;
    sda_m = 1'b1; #Q;
  endtask

  task automatic send_bit(input logic b);
    sda_m = b; #Q;
    scl = 1'b1; #Q;
    #Q;
    scl = 1'b0; #Q;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string tag);
    logic ack;
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_m = 1'b1; #Q;
    scl = 1'b1;   #Q;
    ack = ~sda_line;
    #Q;
    scl = 1'b0;   #Q;
    check(tag, ack, exp_ack);
  endtask

  task automatic recv_byte(input logic ack);
    logic [7:0] got;
    for (int i = 7; i >= 0; i--) begin
      sda_m = 1'b1; #Q;
      scl = 1'b1;   #Q;
      got[i] = sda_line;
      #Q;
      scl = 1'b0;   #Q;
    end
    send_bit(~ack);
    if (exp_rd.size() == 0) check("rd_unexpected", 1, 0);
    else check("rd_byte", got, exp_rd.pop_front());
  endtask

  task automatic host_check(input logic [3:0] idx, input logic [7:0] exp, input string tag);
    host_raddr = idx;
    #1;
    check(tag, host_rdata, exp);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    #23;
    check("rst_sda_oe", sda_oe, 0);
    check("rst_wr_stb", wr_stb, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_busy", busy, 0);
    host_check(4'd7, 8'h00, "rst_reg7");
    rst = 1'b1;
    #(2*Q);

    // Multi-byte write
    exp_wr.push_back('{4'd3, 8'h11});
    exp_wr.push_back('{4'd4, 8'h22});
    bus_start();
    send_byte(8'hA0, 1'b1, "wr_addr_ack");
    check("busy_after_addr", busy, 1);
    send_byte(8'h03, 1'b1, "wr_ptr_ack");
    send_byte(8'h11, 1'b1, "wr_d0_ack");
    send_byte(8'h22, 1'b1, "wr_d1_ack");
    bus_stop();
    #Q;
    host_check(4'd3, 8'h11, "reg3");
    host_check(4'd4, 8'h22, "reg4");

    // Repeated-START read
    bus_start();
    send_byte(8'hA0, 1'b1, "rd_waddr_ack");
    send_byte(8'h03, 1'b1, "rd_ptr_ack");
    bus_start();
    send_byte(8'hA1, 1'b1, "rd_raddr_ack");
    exp_rd.push_back(8'h11);
    exp_rd.push_back(8'h22);
    recv_byte(1'b1);
    recv_byte(1'b0);
    bus_stop();
    #Q;
    check("busy_after_stop", busy, 0);

    // Pointer wrap-around
    exp_wr.push_back('{4'd15, 8'hAA});
    exp_wr.push_back('{4'd0, 8'hBB});
    bus_start();
    send_byte(8'hA0, 1'b1, "wrap_addr_ack");
    send_byte(8'h0F, 1'b1, "wrap_ptr_ack");
    send_byte(8'hAA, 1'b1, "wrap_d0_ack");
    send_byte(8'hBB, 1'b1, "wrap_d1_ack");
    bus_stop();
    #Q;
    host_check(4'd15, 8'hAA, "reg15");
    host_check(4'd0, 8'hBB, "reg0");

    // Upper pointer bits ignored: 0x1F selects 15
    bus_start();
    send_byte(8'hA0, 1'b1, "p1f_addr_ack");
    send_byte(8'h1F, 1'b1, "p1f_ptr_ack");
    bus_start();
    send_byte(8'hA1, 1'b1, "p1f_raddr_ack");
    exp_rd.push_back(8'hAA);
    recv_byte(1'b0);
    bus_stop();
    #Q;

    // Address mismatch
    watch_quiet = 1'b1;
    bus_start();
    send_byte(8'hA2, 1'b0, "mis_addr_nack");
    send_byte(8'h55, 1'b0, "mis_data_nack");
    bus_stop();
    #Q;
    watch_quiet = 1'b0;
    check("mis_oe_seen", oe_seen, 0);
    check("mis_busy_seen", busy_seen, 0);

    // General call
    bus_start();
`ifdef I2C_TGT_GCALL_EN
    exp_wr.push_back('{4'd2, 8'h5A});
    send_byte(8'h00, 1'b1, "gc_addr_ack");
    send_byte(8'h02, 1'b1, "gc_ptr_ack");
    send_byte(8'h5A, 1'b1, "gc_data_ack");
    bus_stop();
    #Q;
    host_check(4'd2, 8'h5A, "gc_reg2");
`else
    send_byte(8'h00, 1'b0, "gc_addr_nack");
    send_byte(8'h02, 1'b0, "gc_ptr_nack");
    send_byte(8'h5A, 1'b0, "gc_data_nack");
    bus_stop();
    #Q;
    host_check(4'd2, 8'h00, "gc_reg2");
`endif

    // Reset while driving a 0 data bit (reg[5] holds 0x00)
    bus_start();
    send_byte(8'hA0, 1'b1, "mr_addr_ack");
    send_byte(8'h05, 1'b1, "mr_ptr_ack");
    bus_start();
    send_byte(8'hA1, 1'b1, "mr_raddr_ack");
    for (int i = 0; i < 50 && !sda_oe; i++) @(posedge clk);
    #2;
    check("mr_oe_before_rst", sda_oe, 1);
    rst = 1'b0;
    #1;
    check("mr_oe_async", sda_oe, 0);
    check("mr_busy", busy, 0);
    #(Q/2);
    rst = 1'b1;
    sda_m = 1'b1;
    #Q;
    scl = 1'b1;
    #Q;

    // Clean transaction after reset
    exp_wr.push_back('{4'd1, 8'h77});
    bus_start();
    send_byte(8'hA0, 1'b1, "post_addr_ack");
    send_byte(8'h01, 1'b1, "post_ptr_ack");
    send_byte(8'h77, 1'b1, "post_data_ack");
    bus_stop();
    #Q;
    host_check(4'd1, 8'h77, "post_reg1");
    host_check(4'd3, 8'h00, "post_reg3_cleared");
    check("post_busy", busy, 0);

    check("wr_queue_empty", exp_wr.size(), 0);
    check("rd_queue_empty", exp_rd.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule

// File: doc/i2c_reg_target.md
# i2c_reg_target

I2C target (responder) with a small internal register file, the counterpart to the team's I2C master on the shared SCL/SDA bus. It oversamples SCL/SDA on the system clock, detects START, repeated START and STOP, and matches a 7-bit device address. It implements pointer-based register writes and reads with auto-increment. A host-side read port and a write strobe expose the register contents to on-chip logic.

## Interface
Parameters:
- DEV_ADDR, 7'h50, 7-bit device address matched after START.
- NREG, 16, number of 8-bit registers. Must be a power of two, 2..256.

Ports:
- clk  input  1  system clock; must be at least 8x the SCL frequency.
- rst  input  1  asynchronous, active-low reset.
- scl_i  input  1  SCL as seen on the bus.
- sda_i  input  1  SDA as seen on the bus.
- sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release.
- wr_stb  output  1  one-cycle pulse when a data byte is committed to a register.
- wr_addr  output  $clog2(NREG)  register index written; valid with wr_stb.
- wr_data  output  8  byte written; valid with wr_stb.
- host_raddr  input  $clog2(NREG)  host read index.
- host_rdata  output  8  reg[host_raddr], combinational.
- busy  output  1  high from the matched-address ACK until STOP or the next START.

## Operation
- Input path: scl_i and sda_i each pass through a 2-FF synchronizer, then a history register. Events are derived from the synchronized signals:
  - SCL rise and SCL fall.
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE.
- START from any state:
  - Go to ADDR.
  - Clear the bit counter.
  - Release sda_oe.
  - The register pointer is kept, so a repeated START can be followed by a read.
- STOP from any state: go to IDLE, release SDA, clear busy.
- ADDR: shift 8 bits MSB-first on SCL rise. After bit 8:
  - Address equals DEV_ADDR: go to ADDR_ACK.
  - Otherwise: go to IGNORE, which waits for START or STOP.
- ADDR_ACK:
  - Drive sda_oe=1 from the first SCL fall after bit 8 until the following SCL fall.
  - Then: R/W=0 goes to PTR; R/W=1 loads the shift register with reg[ptr] and goes to RD_BYTE.
- PTR:
  - Receive one byte. The pointer takes its low $clog2(NREG) bits; upper bits are ignored.
  - ACK it, then go to WR_BYTE.
- WR_BYTE:
  - Receive a byte, then ACK it.
  - At the ACK-slot SCL fall: write reg[ptr], pulse wr_stb, ptr <= ptr+1 modulo NREG (NREG-1 wraps to 0).
  - Loop to WR_BYTE.
- RD_BYTE:
  - Present bit 7 on the SCL fall that ends the ACK slot, then one bit per SCL fall after that.
  - sda_oe = ~bit, so 1 is released and 0 is pulled low.
  - After 8 bits, release SDA and sample the controller's ACK on the next SCL rise.
- RD_ACK:
  - ACK (SDA low): ptr <= ptr+1 (wrapping), reload from reg[ptr], go to RD_BYTE.
  - NACK: go to IGNORE and release SDA until STOP or START.
- Pointer-only write (START, addr+W, ptr, STOP): updates the pointer only; no wr_stb.

## Timing
- Event detection latency: 3 clk from a bus edge to the internal event (2 sync stages + 1 edge stage).
- SDA drive changes only in the cycle after a detected SCL fall. It never changes while SCL is high, except when released on START or STOP.
- wr_stb asserts for exactly one clk, in the cycle after the ACK-slot SCL fall. wr_addr and wr_data are stable in that cycle.
- Reset values:
  - State IDLE, ptr 0, all registers 8'h00.
  - sda_oe 0, wr_stb 0, wr_addr 0, wr_data 0, busy 0.
- Asserting rst mid-transfer releases SDA immediately (asynchronous). The target then stays in IDLE until a new START.
- A START and a STOP are never detected in the same cycle (they need opposite SDA edges). If one coincides with an SCL edge, START or STOP wins.

## Configuration
- I2C_TGT_GCALL_EN defined:
  - Address 7'h00 with R/W=0 is also ACKed and handled as a normal write transaction.
  - Address 7'h00 with R/W=1 is NACKed and goes to IGNORE.
- I2C_TGT_GCALL_EN undefined: 7'h00 is treated as a non-matching address and goes to IGNORE.

## Test plan
- Write: START, 0xA0, 0x03, 0x11, 0x22, STOP.
  - Required: ACK on all 4 bytes.
  - Required: wr_stb pulses with (3,0x11) then (4,0x22).
  - Required: host_rdata at indices 3 and 4 reads 0x11 and 0x22.
- Repeated-START read: START, 0xA0, 0x03, Sr, 0xA1, read 2 bytes (controller ACK then NACK), STOP.
  - Required: bytes returned are 0x11 then 0x22.
  - Required: busy is 0 after STOP.
- Wrap-around: pointer 0x0F, write 0xAA, 0xBB.
  - Required: reg[15]=0xAA and reg[0]=0xBB.
  - Required: a pointer byte of 0x1F selects index 15.
- Address mismatch: START, 0xA2, 0x55, STOP.
  - Required: sda_oe stays 0 throughout, no wr_stb, busy stays 0.
- Reset mid-read: drive rst low while sda_oe=1 during a 0x00 data bit.
  - Required: sda_oe=0 with no clock edge needed.
  - Required: a subsequent clean transaction completes normally.
- General call: with I2C_TGT_GCALL_EN defined, START, 0x00, 0x02, 0x5A, STOP.
  - Required: writes reg[2]=0x5A.
  - Required: without the macro, no ACK and no write.
